// File: rtl/flipper_pkg.sv
// flipper_pkg: shared flipper state type, angle width, ball-stage band limits and saturating angle math
package flipper_pkg;
  typedef enum logic [1:0] {IDLE, RISING, HOLD, FALLING} flip_state_t;
  localparam int ANGLE_W = 7;
  localparam int ANGLE_LOW = 10;
  localparam int ANGLE_MID = 35;
  // One spare bit above the angle width catches the carry before clamping.
  function automatic logic [ANGLE_W-1:0] satAdd(input logic [ANGLE_W-1:0] a, step, limit);
    logic [ANGLE_W:0] sum;
    sum = {1'b0, a} + {1'b0, step};
    return (sum > {1'b0, limit}) ? limit : sum[ANGLE_W-1:0];
  endfunction
  function automatic logic [ANGLE_W-1:0] satSub(input logic [ANGLE_W-1:0] a, step);
    return (a < step) ? '0 : a - step;
  endfunction
endpackage

// File: rtl/flipper_angle_ctrl_if.sv
// flipper_angle_ctrl_if: frame pulse, keys, enable, clear in; angles and kick flags out
// master drives the inputs and observes the outputs; slave is the flipper block.
interface flipper_angle_ctrl_if;
  import flipper_pkg::*;
  logic startOfFrame;
  logic leftKey;
  logic rightKey;
  logic enable;
  logic clearFlippers;
  logic [ANGLE_W-1:0] alphaLeft;
  logic [ANGLE_W-1:0] alphaRight;
  logic kickLeft;
  logic kickRight;
  modport master (
    output startOfFrame, leftKey, rightKey, enable, clearFlippers,
    input alphaLeft, alphaRight, kickLeft, kickRight
  );
  modport slave (
    input startOfFrame, leftKey, rightKey, enable, clearFlippers,
    output alphaLeft, alphaRight, kickLeft, kickRight
  );
endinterface

// File: rtl/flipper_channel.sv
// flipper_channel: one flipper - key synchronizer, edge-to-pend latch, rise/hold/fall FSM
// Ports: clk, reset (sync, active-high), startOfFrame (step strobe), key (async),
// enable, clearFlippers (same effect as reset); alpha (angle), kick (RISING flag).
// FLIPPER_HOLD_LIMIT_EN: HOLD times out after HOLD_FRAMES frame pulses.
module flipper_channel
  import flipper_pkg::*;
#(
  parameter int MAX_ANGLE = 45,
  parameter int UP_STEP = 9,
  parameter int DOWN_STEP = 5,
  parameter int HOLD_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic key,
  input  logic enable,
  input  logic clearFlippers,
  output logic [ANGLE_W-1:0] alpha,
  output logic kick
);
  localparam logic [ANGLE_W-1:0] MAX_A = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] UP_A = ANGLE_W'(UP_STEP);
  localparam logic [ANGLE_W-1:0] DOWN_A = ANGLE_W'(DOWN_STEP);
  flip_state_t state, stateNext;
  logic [ANGLE_W-1:0] angleNext, upAngle, downAngle;
  logic [1:0] keySync, syncValid;
  logic keyPrev, pend, held, keyEdge, holdExpired;
`ifdef FLIPPER_HOLD_LIMIT_EN
  logic [7:0] holdCnt;
  // Counter sits at zero outside HOLD, so every entry to HOLD starts a fresh count.
  always_ff @(posedge clk)
    if (reset || clearFlippers || state != HOLD) holdCnt <= '0;
    else if (startOfFrame) holdCnt <= holdCnt + 8'd1;
  assign holdExpired = ({1'b0, holdCnt} + 9'd1) >= 9'(HOLD_FRAMES);
`else
  // HOLD never times out; legal HOLD_FRAMES is never zero.
  assign holdExpired = HOLD_FRAMES == 0;
`endif
  always_comb begin
    held = keySync[1] & enable;
    // keyPrev starts at 1 after reset/clear, so a key already down must be released first.
    keyEdge = syncValid[1] & keySync[1] & ~keyPrev;
    upAngle = satAdd(alpha, UP_A, MAX_A);
    downAngle = satSub(alpha, DOWN_A);
    stateNext = state;
    angleNext = alpha;
    if (startOfFrame)
      case (state)
        IDLE: if (pend) begin
          stateNext = RISING;
          angleNext = upAngle;
        end
        RISING: begin
          angleNext = held ? upAngle : downAngle;
          stateNext = !held ? FALLING : (upAngle == MAX_A) ? HOLD : RISING;
        end
        HOLD: if (!held || holdExpired) begin
          stateNext = FALLING;
          angleNext = downAngle;
        end
        FALLING: begin
          angleNext = pend ? upAngle : downAngle;
          stateNext = pend ? RISING : (downAngle == '0) ? IDLE : FALLING;
        end
      endcase
  end
  always_ff @(posedge clk)
    if (reset || clearFlippers) begin
      keySync <= '0;
      syncValid <= '0;
      keyPrev <= 1'b1;
      pend <= 1'b0;
      state <= IDLE;
      alpha <= '0;
      kick <= 1'b0;
    end else begin
      keySync <= {keySync[0], key};
      syncValid <= {syncValid[0], 1'b1};
      keyPrev <= syncValid[1] ? keySync[1] : keyPrev;
      // A frame pulse consumes pend; an edge landing on that same cycle survives to the next frame.
      pend <= (pend & ~startOfFrame) | (keyEdge & enable);
      state <= stateNext;
      alpha <= angleNext;
      kick <= stateNext == RISING;
    end
endmodule

// File: rtl/flipper_angle_ctrl.sv
// flipper_angle_ctrl: left/right flipper angles and kick flags for the ball and sprite stages
// Ports: clk, reset (sync, active-high), bus (flipper_angle_ctrl_if.slave: startOfFrame,
// leftKey, rightKey, enable, clearFlippers in; alphaLeft, alphaRight, kickLeft, kickRight out).
// FLIPPER_HOLD_LIMIT_EN: each flipper drops after HOLD_FRAMES frames at full angle.
module flipper_angle_ctrl
  import flipper_pkg::*;
#(
  parameter int MAX_ANGLE = 45,
  parameter int UP_STEP = 9,
  parameter int DOWN_STEP = 5,
  parameter int HOLD_FRAMES = 60
) (
  input logic clk,
  input logic reset,
  flipper_angle_ctrl_if.slave bus
);
  flipper_channel #(
    .MAX_ANGLE(MAX_ANGLE), .UP_STEP(UP_STEP), .DOWN_STEP(DOWN_STEP), .HOLD_FRAMES(HOLD_FRAMES)
  ) leftChan (
    .clk(clk), .reset(reset), .startOfFrame(bus.startOfFrame), .key(bus.leftKey),
    .enable(bus.enable), .clearFlippers(bus.clearFlippers),
    .alpha(bus.alphaLeft), .kick(bus.kickLeft)
  );
  flipper_channel #(
    .MAX_ANGLE(MAX_ANGLE), .UP_STEP(UP_STEP), .DOWN_STEP(DOWN_STEP), .HOLD_FRAMES(HOLD_FRAMES)
  ) rightChan (
    .clk(clk), .reset(reset), .startOfFrame(bus.startOfFrame), .key(bus.rightKey),
    .enable(bus.enable), .clearFlippers(bus.clearFlippers),
    .alpha(bus.alphaRight), .kick(bus.kickRight)
  );
endmodule

// File: tb/tb_flipper_angle_ctrl.sv
// tb_flipper_angle_ctrl: directed and random key stimulus checked against a frame-level flipper model
module tb_flipper_angle_ctrl;
  localparam int MAXA = 45, UP = 9, DN = 5, HF = 3;
`ifdef FLIPPER_HOLD_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RISE = 1, M_HOLD = 2, M_FALL = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0, checks = 0, frames = 0;
  bit checkOn = 1'b0;
  flipper_angle_ctrl_if bus();
  flipper_angle_ctrl #(.MAX_ANGLE(MAXA), .UP_STEP(UP), .DOWN_STEP(DN), .HOLD_FRAMES(HF)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  // Model: key is seen two clocks late; a press counts only after a seen release since reset/clear.
  int mAng[2], mMode[2], mN[2], mHc[2];
  bit mPend[2], mP1[2], mP2[2], mP3[2], mKick[2];
  always @(posedge clk) begin
    if (bus.startOfFrame) frames++;
    for (int c = 0; c < 2; c++) begin
      if (reset || bus.clearFlippers) begin
        mAng[c] = 0; mMode[c] = M_IDLE; mN[c] = 0; mHc[c] = 0;
        mPend[c] = 0; mP1[c] = 0; mP2[c] = 0; mP3[c] = 0; mKick[c] = 0;
      end else begin
        bit keyNow, seenEdge, seenHeld;
        keyNow = (c == 0) ? bus.leftKey : bus.rightKey;
        seenEdge = mN[c] >= 3 && mP2[c] && !mP3[c] && bus.enable;
        seenHeld = mN[c] >= 2 && mP2[c] && bus.enable;
        if (bus.startOfFrame)
          case (mMode[c])
            M_IDLE: if (mPend[c]) begin mMode[c] = M_RISE; mAng[c] = (UP > MAXA) ? MAXA : UP; end
            M_RISE: if (!seenHeld) begin
              mMode[c] = M_FALL; mAng[c] = (mAng[c] > DN) ? mAng[c] - DN : 0;
            end else begin
              mAng[c] = (mAng[c] + UP > MAXA) ? MAXA : mAng[c] + UP;
              if (mAng[c] == MAXA) begin mMode[c] = M_HOLD; mHc[c] = 0; end
            end
            M_HOLD: begin
              mHc[c]++;
              if (!seenHeld || (LIMIT && mHc[c] >= HF)) begin mMode[c] = M_FALL; mAng[c] = MAXA - DN; end
            end
            default: if (mPend[c]) begin
              mMode[c] = M_RISE; mAng[c] = (mAng[c] + UP > MAXA) ? MAXA : mAng[c] + UP;
            end else begin
              mAng[c] = (mAng[c] > DN) ? mAng[c] - DN : 0;
              if (mAng[c] == 0) mMode[c] = M_IDLE;
            end
          endcase
        mPend[c] = (bus.startOfFrame ? 1'b0 : mPend[c]) | seenEdge;
        mP3[c] = mP2[c]; mP2[c] = mP1[c]; mP1[c] = keyNow;
        if (mN[c] < 3) mN[c]++;
        mKick[c] = mMode[c] == M_RISE;
      end
    end
  end
  always @(negedge clk)
    if (checkOn) begin
      checkVal("alphaLeft", 32'(bus.alphaLeft), 32'(mAng[0]));
      checkVal("alphaRight", 32'(bus.alphaRight), 32'(mAng[1]));
      checkVal("kickLeft", 32'(bus.kickLeft), 32'(mKick[0]));
      checkVal("kickRight", 32'(bus.kickRight), 32'(mKick[1]));
    end
  initial begin
    bus.startOfFrame = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      bus.startOfFrame = 1'b1;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
    end
  end
  // Returns on the negedge right after the next frame pulse has been applied.
  task automatic nextFrame;
    int f, t;
    f = frames;
    t = 0;
    do begin @(negedge clk); t++; end while (frames == f && t < 100);
    if (frames == f) checkVal("frameTimeout", 0, 1);
  endtask
  initial begin
    bus.leftKey = 1'b1; bus.rightKey = 1'b1; bus.enable = 1'b1; bus.clearFlippers = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOn = 1'b1;
    checkVal("rstAlphaL", 32'(bus.alphaLeft), 0);
    checkVal("rstAlphaR", 32'(bus.alphaRight), 0);
    checkVal("rstKickL", 32'(bus.kickLeft), 0);
    repeat (3) nextFrame();
    checkVal("heldThruRstL", 32'(bus.alphaLeft), 0);
    checkVal("heldThruRstR", 32'(bus.alphaRight), 0);
    bus.leftKey = 1'b0; bus.rightKey = 1'b0;
    nextFrame();
    bus.leftKey = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      nextFrame();
      checkVal("riseL", 32'(bus.alphaLeft), 32'(UP * k));
      checkVal("riseKickL", 32'(bus.kickLeft), 32'(k < 5));
      checkVal("riseQuietR", 32'(bus.alphaRight), 0);
    end
    nextFrame();
    checkVal("holdL", 32'(bus.alphaLeft), 45);
    bus.leftKey = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      nextFrame();
      checkVal("fallL", 32'(bus.alphaLeft), 32'(MAXA - DN * k));
    end
    nextFrame();
    checkVal("idleL", 32'(bus.alphaLeft), 0);
    @(negedge clk);
    bus.rightKey = 1'b1;
    repeat (4) @(negedge clk);
    bus.rightKey = 1'b0;
    nextFrame();
    checkVal("tapR1", 32'(bus.alphaRight), 9);
    nextFrame();
    checkVal("tapR2", 32'(bus.alphaRight), 4);
    nextFrame();
    checkVal("tapR3", 32'(bus.alphaRight), 0);
    bus.leftKey = 1'b1;
    repeat (5) nextFrame();
    bus.leftKey = 1'b0;
    repeat (5) nextFrame();
    checkVal("fallTo20", 32'(bus.alphaLeft), 20);
    bus.leftKey = 1'b1;
    nextFrame();
    checkVal("repress", 32'(bus.alphaLeft), 29);
    checkVal("repressKick", 32'(bus.kickLeft), 1);
    bus.leftKey = 1'b0;
    repeat (12) nextFrame();
    bus.leftKey = 1'b1;
    repeat (3) nextFrame();
    checkVal("preClear", 32'(bus.alphaLeft), 27);
    repeat (2) @(negedge clk);
    bus.clearFlippers = 1'b1;
    @(negedge clk);
    bus.clearFlippers = 1'b0;
    checkVal("clearAlpha", 32'(bus.alphaLeft), 0);
    checkVal("clearKick", 32'(bus.kickLeft), 0);
    nextFrame();
    checkVal("noRiseAfterClear", 32'(bus.alphaLeft), 0);
    bus.leftKey = 1'b0;
    nextFrame();
    bus.leftKey = 1'b1;
    repeat (105) nextFrame();
    checkVal("longHold", 32'(bus.alphaLeft), LIMIT ? 0 : MAXA);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(5) == 0) bus.leftKey = ~bus.leftKey;
      if ($urandom_range(5) == 0) bus.rightKey = ~bus.rightKey;
      bus.enable = $urandom_range(19) != 0;
      bus.clearFlippers = $urandom_range(299) == 0;
    end
    bus.enable = 1'b1;
    bus.clearFlippers = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
